// File: rtl/load_store_unit.sv
// ============================================================================
// Module  : load_store_unit
// Brief   : Byte-addressed load/store front end for a word-addressed memory.
// Revision: 1.0
// ============================================================================
`default_nettype none

module load_store_unit #(
    parameter int MEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_we,
    input  logic [1:0]  i_req_size,
    input  logic        i_req_unsigned,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    output logic        o_resp_valid,
    input  logic        i_resp_ready,
    output logic [31:0] o_resp_rdata,
    output logic        o_resp_err,
    output logic        o_mem_enable,
    output logic        o_mem_rw,
    output logic [31:0] o_mem_ain,
    output logic [31:0] o_mem_din,
    input  logic [31:0] i_mem_dout
);

    localparam logic [31:0] C_MEM_WORDS = 32'(MEM_WORDS);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RD    = 3'd1;
    localparam logic [2:0] S_CAP   = 3'd2;
    localparam logic [2:0] S_MERGE = 3'd3;
    localparam logic [2:0] S_WR    = 3'd4;
    localparam logic [2:0] S_RESP  = 3'd5;

    logic [2:0]  r_state;
    logic [2:0]  w_next;
    logic        r_we;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [1:0]  r_lane;
    logic [15:0] r_wdata;
    logic [31:0] r_ain;
    logic [31:0] r_din;
    logic [31:0] r_rdata;
    logic        r_err;

    logic        w_accept;
    logic        w_err;
    logic [4:0]  w_lane_sh;
    logic [31:0] w_shift;
    logic [31:0] w_load;
    logic [31:0] w_mask;
    logic [31:0] w_merged;

    assign w_accept  = i_req_valid && o_req_ready;
    assign w_lane_sh = {r_lane, 3'b000};
    assign w_shift   = i_mem_dout >> w_lane_sh;

    always_comb begin
        w_err = 1'b0;
        case (i_req_size)
            2'b00:   w_err = 1'b0;
            2'b01:   w_err = i_req_addr[0];
            2'b10:   w_err = |i_req_addr[1:0];
            default: w_err = 1'b1;
        endcase
        if ({2'b00, i_req_addr[31:2]} >= C_MEM_WORDS) begin
            w_err = 1'b1;
        end
    end

    // Lane data is shifted down to bit 0 before extension.
    always_comb begin
        w_load = 32'h0;
        case (r_size)
            2'b00:   w_load = {{24{~r_unsigned & w_shift[7]}}, w_shift[7:0]};
            2'b01:   w_load = {{16{~r_unsigned & w_shift[15]}}, w_shift[15:0]};
            2'b10:   w_load = i_mem_dout;
            default: w_load = 32'h0;
        endcase
    end

    always_comb begin
        w_mask   = 32'h0;
        w_merged = i_mem_dout;
        if (r_size == 2'b00) begin
            w_mask   = 32'h0000_00FF << w_lane_sh;
            w_merged = (i_mem_dout & ~w_mask) | ({24'h0, r_wdata[7:0]} << w_lane_sh);
        end else if (r_size == 2'b01) begin
            w_mask   = 32'h0000_FFFF << w_lane_sh;
            w_merged = (i_mem_dout & ~w_mask) | ({16'h0, r_wdata} << w_lane_sh);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_err)                                  w_next = S_RESP;
                    else if (i_req_we && i_req_size == 2'b10)   w_next = S_WR;
                    else                                        w_next = S_RD;
                end
            end
            S_RD:    w_next = r_we ? S_MERGE : S_CAP;
            S_CAP:   w_next = S_RESP;
            S_MERGE: w_next = S_WR;
            S_WR:    w_next = S_RESP;
            S_RESP:  w_next = i_resp_ready ? S_IDLE : S_RESP;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        o_req_ready  = (r_state == S_IDLE) && rst_n;
        o_resp_valid = (r_state == S_RESP);
        o_mem_enable = (r_state == S_RD) || (r_state == S_WR);
        o_mem_rw     = (r_state == S_WR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we       <= 1'b0;
            r_size     <= 2'b00;
            r_unsigned <= 1'b0;
            r_lane     <= 2'b00;
            r_wdata    <= 16'h0;
            r_ain      <= 32'h0;
            r_din      <= 32'h0;
            r_rdata    <= 32'h0;
            r_err      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_we       <= i_req_we;
                r_size     <= i_req_size;
                r_unsigned <= i_req_unsigned;
                r_lane     <= i_req_addr[1:0];
                r_wdata    <= i_req_wdata[15:0];
                r_ain      <= {2'b00, i_req_addr[31:2]};
                r_rdata    <= 32'h0;
                r_err      <= w_err;
                if (i_req_we && i_req_size == 2'b10) begin
                    r_din <= i_req_wdata;
                end
            end
            if (r_state == S_CAP) begin
                r_rdata <= w_load;
            end
            if (r_state == S_MERGE) begin
                r_din <= w_merged;
            end
        end
    end

    assign o_resp_rdata = r_rdata;
    assign o_resp_err   = r_err;
    assign o_mem_ain    = r_ain;
    assign o_mem_din    = r_din;

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// ============================================================================
// Module  : tb_load_store_unit
// Brief   : Randomized self-checking bench with a byte-level reference model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_enable;
    logic        mem_rw;
    logic [31:0] mem_ain;
    logic [31:0] mem_din;
    logic [31:0] mem_dout = 32'h0;

    int n_total = 0;
    int n_bad   = 0;

    logic [31:0] env_mem [0:1023];
    logic [7:0]  ref_bytes [0:4095];

    int          en_cnt  = 0;
    int          wr_cnt  = 0;
    int          ain_bad = 0;
    logic [31:0] exp_idx = 32'h0;

    load_store_unit #(.MEM_WORDS(1024)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_req_valid    (req_valid),
        .o_req_ready    (req_ready),
        .i_req_we       (req_we),
        .i_req_size     (req_size),
        .i_req_unsigned (req_unsigned),
        .i_req_addr     (req_addr),
        .i_req_wdata    (req_wdata),
        .o_resp_valid   (resp_valid),
        .i_resp_ready   (resp_ready),
        .o_resp_rdata   (resp_rdata),
        .o_resp_err     (resp_err),
        .o_mem_enable   (mem_enable),
        .o_mem_rw       (mem_rw),
        .o_mem_ain      (mem_ain),
        .o_mem_din      (mem_din),
        .i_mem_dout     (mem_dout)
    );

    always #5 clk = ~clk;

    // Attached synchronous memory: read data appears the cycle after the read edge.
    always @(posedge clk) begin
        if (mem_enable && mem_ain < 32'd1024) begin
            if (mem_rw) env_mem[mem_ain[9:0]] <= mem_din;
            else        mem_dout <= env_mem[mem_ain[9:0]];
        end
    end

    always @(negedge clk) begin
        if (mem_enable) begin
            en_cnt = en_cnt + 1;
            if (mem_rw) wr_cnt = wr_cnt + 1;
            if (mem_ain !== exp_idx) ain_bad = ain_bad + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd, input int hold);
        int          nbytes;
        logic        e_err;
        logic [31:0] e_rd;
        int          e_lat, e_en, e_wr, lat, en0, wr0, ab0;
        logic [31:0] idx;
        nbytes = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        idx    = addr / 4;
        e_err  = (sz == 2'b11) || (addr % nbytes != 0) || (idx >= 1024);
        e_rd   = 32'h0;
        if (e_err) begin
            e_lat = 1; e_en = 0; e_wr = 0;
        end else if (we) begin
            e_lat = (nbytes == 4) ? 2 : 4;
            e_en  = (nbytes == 4) ? 1 : 2;
            e_wr  = 1;
            for (int i = 0; i < nbytes; i++) ref_bytes[addr + i] = wd[8*i +: 8];
        end else begin
            e_lat = 3; e_en = 1; e_wr = 0;
            for (int i = 0; i < nbytes; i++) e_rd[8*i +: 8] = ref_bytes[addr + i];
            if (!uns && nbytes < 4 && e_rd[8*nbytes-1])
                for (int i = nbytes; i < 4; i++) e_rd[8*i +: 8] = 8'hFF;
        end
        exp_idx = idx;
        en0 = en_cnt; wr0 = wr_cnt; ab0 = ain_bad;
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = addr; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_wdata = $urandom;
        lat = 1;
        while (!resp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", 32'(lat), 32'(e_lat));
        chk("rdata", resp_rdata, e_rd);
        chk("err", {31'h0, resp_err}, {31'h0, e_err});
        if (!e_err) chk("mem_ain", mem_ain, idx);
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            chk("hold_valid", {31'h0, resp_valid}, 32'h1);
            chk("hold_ready", {31'h0, req_ready}, 32'h0);
            chk("hold_rdata", resp_rdata, e_rd);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        chk("back_idle", {30'h0, resp_valid, req_ready}, 32'h1);
        chk("en_pulses", 32'(en_cnt - en0), 32'(e_en));
        chk("wr_pulses", 32'(wr_cnt - wr0), 32'(e_wr));
        chk("ain_during_pulse", 32'(ain_bad - ab0), 32'h0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk(tag, {req_ready, resp_valid, resp_err, mem_enable, mem_rw, 27'h0},
            32'h0);
        chk(tag, resp_rdata | mem_ain | mem_din, 32'h0);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) env_mem[i] = 32'h0;
        for (int i = 0; i < 4096; i++) ref_bytes[i] = 8'h0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset_state");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("ready_after_reset", {31'h0, req_ready}, 32'h1);

        // Word store / load and latencies
        do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 0);
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0);
        // Byte store into a known word, signed/unsigned reload
        do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344, 0);
        do_req(1'b1, 2'b00, 1'b0, 32'h13, 32'h55AA5580, 0);
        do_req(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 0);
        do_req(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 0);
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0);
        // Half store/load and misaligned half
        do_req(1'b1, 2'b01, 1'b0, 32'h22, 32'h1234ABCD, 0);
        do_req(1'b0, 2'b01, 1'b0, 32'h22, 32'h0, 0);
        do_req(1'b0, 2'b01, 1'b0, 32'h21, 32'h0, 0);
        // Out of range and illegal size
        do_req(1'b0, 2'b10, 1'b0, 32'h1000, 32'h0, 0);
        do_req(1'b0, 2'b11, 1'b0, 32'h0, 32'h0, 0);
        do_req(1'b1, 2'b00, 1'b0, 32'hFFFF_FFFC, 32'h77, 0);
        // Back-pressure
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 5);

        // Reset while the byte store sits in MERGE: target word must survive
        begin
            int wr0;
            wr0 = wr_cnt;
            req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
            req_addr = 32'h11; req_wdata = 32'h000000EE;
            @(posedge clk); #1;
            req_valid = 1'b0;
            @(posedge clk); #1;
            rst_n = 1'b0;
            #1;
            chk_reset_outputs("reset_in_merge");
            repeat (2) @(posedge clk);
            @(negedge clk);
            rst_n = 1'b1;
            #1;
            chk("ready_after_abort", {31'h0, req_ready}, 32'h1);
            chk("abort_no_write", 32'(wr_cnt - wr0), 32'h0);
            do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0);
        end

        // Randomized traffic in a small window plus occasional wild addresses
        for (int n = 0; n < 120; n++) begin
            logic [31:0] a;
            logic [1:0]  s;
            a = $urandom_range(0, 63);
            if ($urandom_range(0, 15) == 0) a = $urandom;
            if ($urandom_range(0, 15) == 1) a = 32'h0000_0FF0 + $urandom_range(0, 31);
            s = 2'($urandom_range(0, 2));
            if ($urandom_range(0, 11) == 0) s = 2'b11;
            if ($urandom_range(0, 2) != 0) begin
                if (s == 2'b01) a[0] = 1'b0;
                if (s == 2'b10) a[1:0] = 2'b00;
            end
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            do_req(1'($urandom), s, 1'($urandom), a, $urandom, $urandom_range(0, 2));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
